// File: rtl/divider_array_reconstruct_seq.sv
// Sequential reconstruction checker: recomputes q*d + r with an 8-step
// shift-add multiplier and compares it against the dividend n. It reports
// the per-sample absolute error and keeps saturating error statistics.
module divider_array_reconstruct_seq #(
   parameter int SUM_W = 24,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [15:0]      n,
   input  logic [7:0]       d,
   input  logic [7:0]       q,
   input  logic [7:0]       r,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [15:0]      prod,
   output logic [15:0]      err_abs,
   output logic             match,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             clr_stats,
   output logic [SUM_W-1:0] err_sum,
   output logic [CNT_W-1:0] sample_cnt
);

   typedef enum logic [1:0] {IDLE, MUL, FIN, DONE} state_t;

   // Wide enough to hold err_sum + err_abs without losing the carry.
   localparam int EXT_W = ((SUM_W > 16) ? SUM_W : 16) + 1;

   state_t           state_q, state_d;
   logic [15:0]      n_q, n_d;
   logic [7:0]       d_q, d_d;
   logic [7:0]       q_q, q_d;
   logic [7:0]       r_q, r_d;
   logic [16:0]      acc_q, acc_d;
   logic [2:0]       step_q, step_d;
   logic [15:0]      prod_q, prod_d;
   logic [15:0]      err_abs_q, err_abs_d;
   logic             match_q, match_d;
   logic [SUM_W-1:0] err_sum_q, err_sum_d;
   logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;

   logic [16:0]      addend;
   logic [15:0]      fin_prod;
   logic [15:0]      fin_err;
   logic [SUM_W-1:0] sum_base;
   logic [CNT_W-1:0] cnt_base;

   function automatic logic [SUM_W-1:0] sat_add_sum(input logic [SUM_W-1:0] a,
                                                   input logic [15:0] b);
      logic [EXT_W-1:0] s;
      s = EXT_W'(a) + EXT_W'(b);
      if (s > EXT_W'({SUM_W{1'b1}}))
         return {SUM_W{1'b1}};
      return s[SUM_W-1:0];
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] a);
      if (&a)
         return a;
      return a + CNT_W'(1);
   endfunction

   // Datapath helpers: shifted partial product and final reconstruction.
   always_comb begin
      addend   = 17'(d_q) << step_q;
      fin_prod = 16'(acc_q + 17'(r_q));
      fin_err  = (fin_prod >= n_q) ? (fin_prod - n_q) : (n_q - fin_prod);
      // A clear in the same cycle as a FIN update is applied before the add.
      sum_base = clr_stats ? '0 : err_sum_q;
      cnt_base = clr_stats ? '0 : sample_cnt_q;
   end

   // Next-state, datapath and statistics update.
   always_comb begin
      state_d      = state_q;
      n_d          = n_q;
      d_d          = d_q;
      q_d          = q_q;
      r_d          = r_q;
      acc_d        = acc_q;
      step_d       = step_q;
      prod_d       = prod_q;
      err_abs_d    = err_abs_q;
      match_d      = match_q;
      err_sum_d    = sum_base;
      sample_cnt_d = cnt_base;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               n_d     = n;
               d_d     = d;
               q_d     = q;
               r_d     = r;
               acc_d   = '0;
               step_d  = '0;
               state_d = MUL;
            end
         end
         MUL: begin
            if (q_q[0])
               acc_d = acc_q + addend;
            q_d    = q_q >> 1;
            step_d = step_q + 3'd1;
            if (step_q == 3'd7)
               state_d = FIN;
         end
         FIN: begin
            prod_d       = fin_prod;
            err_abs_d    = fin_err;
            match_d      = (fin_prod == n_q);
            err_sum_d    = sat_add_sum(sum_base, fin_err);
            sample_cnt_d = sat_inc_cnt(cnt_base);
            state_d      = DONE;
         end
         DONE: begin
            if (out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control, visible results and statistics: cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         prod_q       <= '0;
         err_abs_q    <= '0;
         match_q      <= 1'b0;
         err_sum_q    <= '0;
         sample_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         prod_q       <= prod_d;
         err_abs_q    <= err_abs_d;
         match_q      <= match_d;
         err_sum_q    <= err_sum_d;
         sample_cnt_q <= sample_cnt_d;
      end
   end

   // Operand and accumulator registers: always reloaded on accept.
   always_ff @(posedge clk) begin
      n_q    <= n_d;
      d_q    <= d_d;
      q_q    <= q_d;
      r_q    <= r_d;
      acc_q  <= acc_d;
      step_q <= step_d;
   end

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = (state_q == DONE);
   assign prod       = prod_q;
   assign err_abs    = err_abs_q;
   assign match      = match_q;
   assign err_sum    = err_sum_q;
   assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_divider_array_reconstruct_seq.sv
// Bench for divider_array_reconstruct_seq: directed and random samples
// checked against an arithmetic reference (q*d + r, |prod - n|, running sums).
module tb_divider_array_reconstruct_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] n;
   logic [7:0]  d, q, r;
   logic        in_valid, out_ready, clr_stats;
   logic        in_ready, out_valid, match;
   logic [15:0] prod, err_abs;
   logic [23:0] err_sum;
   logic [15:0] sample_cnt;

   logic        in_ready8, out_valid8, match8;
   logic [15:0] prod8, err_abs8;
   logic [7:0]  err_sum8;
   logic [15:0] sample_cnt8;

   int          n_cmp = 0;
   int          n_bad = 0;
   longint      sum_ref;
   int          cnt_ref;
   logic [15:0] e_prod, e_err;
   logic        e_match;

   always #5 clk = ~clk;

   divider_array_reconstruct_seq dut (
      .clk(clk), .rst(rst), .n(n), .d(d), .q(q), .r(r),
      .in_valid(in_valid), .in_ready(in_ready),
      .prod(prod), .err_abs(err_abs), .match(match), .out_valid(out_valid),
      .out_ready(out_ready), .clr_stats(clr_stats),
      .err_sum(err_sum), .sample_cnt(sample_cnt)
   );

   divider_array_reconstruct_seq #(.SUM_W(8), .CNT_W(16)) dut8 (
      .clk(clk), .rst(rst), .n(n), .d(d), .q(q), .r(r),
      .in_valid(in_valid), .in_ready(in_ready8),
      .prod(prod8), .err_abs(err_abs8), .match(match8), .out_valid(out_valid8),
      .out_ready(out_ready), .clr_stats(clr_stats),
      .err_sum(err_sum8), .sample_cnt(sample_cnt8)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] sat_ref(input longint v, input longint mx);
      return (v > mx) ? 32'(mx) : 32'(v);
   endfunction

   task automatic check_out(input string tg);
      chk({tg, ":out_valid"}, out_valid, 1);
      chk({tg, ":prod"}, prod, e_prod);
      chk({tg, ":err_abs"}, err_abs, e_err);
      chk({tg, ":match"}, match, e_match);
      chk({tg, ":err_sum"}, err_sum, sat_ref(sum_ref, 64'hFFFFFF));
      chk({tg, ":sample_cnt"}, sample_cnt, sat_ref(longint'(cnt_ref), 64'hFFFF));
      chk({tg, ":err_sum8"}, err_sum8, sat_ref(sum_ref, 64'hFF));
   endtask

   // One transaction: accept, latency check, optional clear on the FIN edge,
   // backpressure for 'stall' cycles, then consume.
   task automatic run(input logic [15:0] nn, input logic [7:0] dd, input logic [7:0] qq,
                      input logic [7:0] rr, input bit clr, input int stall, input string tg);
      int p;
      p       = int'(qq) * int'(dd) + int'(rr);
      e_prod  = p[15:0];
      e_err   = (p >= int'(nn)) ? 16'(p - int'(nn)) : 16'(int'(nn) - p);
      e_match = (p == int'(nn));
      chk({tg, ":in_ready_idle"}, in_ready, 1);
      n = nn; d = dd; q = qq; r = rr; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 16'($urandom); d = 8'($urandom); q = 8'($urandom); r = 8'($urandom);
      chk({tg, ":in_ready_busy"}, in_ready, 0);
      for (int k = 1; k <= 8; k++) begin
         if (k == 4) in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
      end
      chk({tg, ":early_valid"}, out_valid, 0);
      clr_stats = clr;
      tick();
      clr_stats = 1'b0;
      if (clr) begin
         sum_ref = 0;
         cnt_ref = 0;
      end
      sum_ref += longint'(e_err);
      cnt_ref++;
      check_out(tg);
      for (int k = 0; k < stall; k++) begin
         in_valid = 1'($urandom_range(0, 1));
         n = 16'($urandom); d = 8'($urandom); q = 8'($urandom); r = 8'($urandom);
         tick();
         check_out({tg, ":hold"});
         chk({tg, ":hold_in_ready"}, in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tg, ":consumed_ready"}, in_ready, 1);
      chk({tg, ":consumed_valid"}, out_valid, 0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_stats = 1'b0;
      n = '0; d = '0; q = '0; r = '0;
      sum_ref = 0; cnt_ref = 0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst:in_ready", in_ready, 1);
      chk("rst:out_valid", out_valid, 0);
      chk("rst:prod", prod, 0);
      chk("rst:err_abs", err_abs, 0);
      chk("rst:match", match, 0);
      chk("rst:err_sum", err_sum, 0);
      chk("rst:sample_cnt", sample_cnt, 0);

      run(16'd1000, 8'd7, 8'd142, 8'd6, 1'b0, 0, "exact");
      run(16'd1000, 8'd7, 8'd255, 8'd255, 1'b0, 0, "approx1");
      run(16'd50, 8'd5, 8'd9, 8'd0, 1'b0, 0, "approx2");
      chk("approx2:sum_abs", err_sum, 1045);
      run(16'd0, 8'd255, 8'd255, 8'd255, 1'b0, 0, "maxwidth");
      run(16'd0, 8'd0, 8'd0, 8'd0, 1'b0, 0, "zero");
      run(16'd777, 8'd13, 8'd59, 8'd10, 1'b0, 5, "backpressure");

      // Clear in a cycle with no FIN update.
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
      sum_ref = 0; cnt_ref = 0;
      chk("clr_idle:err_sum", err_sum, 0);
      chk("clr_idle:sample_cnt", sample_cnt, 0);

      run(16'd3, 8'd1, 8'd6, 8'd4, 1'b0, 0, "pre_clr");
      run(16'd10, 8'd1, 8'd3, 8'd0, 1'b1, 0, "clr_fin");
      chk("clr_fin:err_sum7", err_sum, 7);
      chk("clr_fin:cnt1", sample_cnt, 1);

      run(16'd0, 8'd1, 8'd200, 8'd0, 1'b1, 0, "sat1");
      run(16'd0, 8'd1, 8'd200, 8'd0, 1'b0, 2, "sat2");
      chk("sat2:err_sum8_full", err_sum8, 255);

      for (int i = 0; i < 20; i++)
         run(16'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             ($urandom_range(0, 4) == 0), int'($urandom_range(0, 3)), "rand");

      // Reset in the middle of the multiply phase.
      n = 16'd123; d = 8'd9; q = 8'd14; r = 8'd3; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 1; k <= 3; k++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sum_ref = 0; cnt_ref = 0;
      chk("midrst:in_ready", in_ready, 1);
      chk("midrst:out_valid", out_valid, 0);
      chk("midrst:prod", prod, 0);
      chk("midrst:err_abs", err_abs, 0);
      chk("midrst:match", match, 0);
      chk("midrst:err_sum", err_sum, 0);
      chk("midrst:sample_cnt", sample_cnt, 0);
      for (int k = 0; k < 12; k++) begin
         tick();
         chk("midrst:no_valid", out_valid, 0);
      end
      run(16'd1000, 8'd7, 8'd142, 8'd6, 1'b0, 1, "after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
